// File: rtl/wrap_pkg.sv
// wrap_pkg: shared state encoding and default byte width for the wrap_out slice
package wrap_pkg;
  localparam int BYTE_W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd2} state_t;
endpackage

// File: rtl/wrap_out_if.sv
// wrap_out_if: result-word capture request and byte-stream handshake bundle
interface wrap_out_if #(
  parameter int NBYTES = 2,
  parameter int BYTE_W = wrap_pkg::BYTE_W_DEF
);
  logic                     start;
  logic [NBYTES*BYTE_W-1:0] yout;
  logic [BYTE_W-1:0]        bus;
  logic                     bus_valid;
  logic                     bus_ack;
  logic                     busy;
  logic                     done;
  modport master (output start, yout, bus_ack, input bus, bus_valid, busy, done);
  modport slave  (input start, yout, bus_ack, output bus, bus_valid, busy, done);
endinterface

// File: rtl/wrap_out_dp.sv
// wrap_out_dp: shift register, byte counter and zero-gated bus mux for wrap_out
module wrap_out_dp import wrap_pkg::*; #(
  parameter int NBYTES = 2,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_ld,
  input  logic                     i_shift,
  input  logic                     i_rstcnt,
  input  logic                     i_en,
  input  logic [NBYTES*BYTE_W-1:0] i_yout,
  output logic [BYTE_W-1:0]        o_bus,
  output logic                     o_last
);
  localparam int CW = $clog2(NBYTES);
  logic [NBYTES*BYTE_W-1:0] r_sr;
  logic [CW-1:0]            r_cnt;
  assign o_bus  = i_en ? r_sr[BYTE_W-1:0] : '0;
  assign o_last = r_cnt == CW'(NBYTES - 1);
  // load a fresh word, drop each accepted byte off the bottom, wrap the counter on the last byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_ld) begin
      r_sr  <= i_yout;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr  <= r_sr >> BYTE_W;
      r_cnt <= r_cnt + CW'(1);
    end else if (i_rstcnt)
      r_cnt <= '0;
endmodule

// File: rtl/wrap_out.sv
// wrap_out: serialises a captured result word onto a byte bus, LSB first, with ack backpressure
module wrap_out import wrap_pkg::*; #(
  parameter int NBYTES = 2,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  wrap_out_if.slave  wif
);
  state_t r_state;
  logic   r_valid, r_busy, r_done;
  logic   w_last, w_ld, w_xfer, w_shift, w_rstcnt;
  assign w_ld     = (r_state == IDLE) && wif.start;
  assign w_xfer   = (r_state == SEND) && wif.bus_ack;
  assign w_shift  = w_xfer && !w_last;
  assign w_rstcnt = w_xfer && w_last;
  assign wif.bus_valid = r_valid;
  assign wif.busy      = r_busy;
  assign wif.done      = r_done;
  wrap_out_dp #(.NBYTES(NBYTES), .BYTE_W(BYTE_W)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .i_ld     (w_ld),
    .i_shift  (w_shift),
    .i_rstcnt (w_rstcnt),
    .i_en     (r_valid),
    .i_yout   (wif.yout),
    .o_bus    (wif.bus),
    .o_last   (w_last)
  );
  // controller: start only honoured in IDLE, last accepted byte moves to FIN for the one-cycle done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else
      case (r_state)
        IDLE: if (wif.start) begin
          r_state <= SEND;
          r_valid <= 1'b1;
          r_busy  <= 1'b1;
        end
        SEND: if (w_rstcnt) begin
          r_state <= FIN;
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_wrap_out.sv
// tb_wrap_out: random and directed checks of wrap_out (NBYTES=2 and 4) against a word/byte-index model
module tb_wrap_out;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] yout = '0;
  int          checks = 0;
  int          fails = 0;
  int          ndone2 = 0;
  int          ph [2];
  int          idx [2];
  logic [31:0] wd [2];
  int          nb [2] = '{2, 4};

  always #5 clk = ~clk;

  wrap_out_if #(.NBYTES(2), .BYTE_W(8)) if2 ();
  wrap_out_if #(.NBYTES(4), .BYTE_W(8)) if4 ();
  assign if2.start   = start;
  assign if4.start   = start;
  assign if2.bus_ack = ack;
  assign if4.bus_ack = ack;
  assign if2.yout    = yout[15:0];
  assign if4.yout    = yout;

  wrap_out #(.NBYTES(2), .BYTE_W(8)) dut2 (.clk(clk), .rst(rst), .wif(if2));
  wrap_out #(.NBYTES(4), .BYTE_W(8)) dut4 (.clk(clk), .rst(rst), .wif(if4));

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // model: ph 0=waiting for start, 1=sending byte idx of wd, 2=done cycle
  initial begin
    ph = '{0, 0};
    idx = '{0, 0};
  end
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        ph[k]  = 0;
        idx[k] = 0;
      end else if (ph[k] == 0) begin
        if (start) begin
          ph[k]  = 1;
          idx[k] = 0;
          wd[k]  = (k == 1) ? yout : {16'h0, yout[15:0]};
        end
      end else if (ph[k] == 1) begin
        if (ack) begin
          idx[k]++;
          if (idx[k] == nb[k]) ph[k] = 2;
        end
      end else
        ph[k] = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] eb;
      eb = (ph[k] == 1) ? 8'(wd[k] >> (8 * idx[k])) : 8'h00;
      chk($sformatf("bus%0d", k), k == 1 ? if4.bus : if2.bus, eb);
      chk($sformatf("valid%0d", k), k == 1 ? if4.bus_valid : if2.bus_valid, ph[k] == 1);
      chk($sformatf("busy%0d", k), k == 1 ? if4.busy : if2.busy, ph[k] != 0);
      chk($sformatf("done%0d", k), k == 1 ? if4.done : if2.done, ph[k] == 2);
    end
    if (if2.done) ndone2++;
  end

  task automatic wait_idle();
    int n = 0;
    while ((if2.busy || if4.busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 40, 1);
  endtask

  task automatic go(input logic [31:0] w);
    yout  = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_bus", if2.bus, 0);
    chk("rst_valid", if2.bus_valid, 0);
    chk("rst_busy", if4.busy, 0);
    chk("rst_done", if4.done, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    // basic transfer
    ack = 1'b1;
    go(32'h0000A55A);
    chk("basic_b0", if2.bus, 8'h5A);
    @(negedge clk);
    chk("basic_b1", if2.bus, 8'hA5);
    @(negedge clk);
    chk("basic_done", if2.done, 1);
    wait_idle();
    // backpressure
    ack = 1'b0;
    go(32'h00001234);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold", {if2.bus_valid, if2.bus}, 9'h134);
      if (i < 3) @(negedge clk);
    end
    ack = 1'b1;
    @(negedge clk);
    chk("bp_b1", if2.bus, 8'h12);
    @(negedge clk);
    chk("bp_done", if2.done, 1);
    wait_idle();
    // start while busy
    d0 = ndone2;
    go(32'h00005678);
    chk("busy_b0", if2.bus, 8'h78);
    yout  = 32'h0000FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_b1", if2.bus, 8'h56);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("busy_one_done", ndone2 - d0, 1);
    // reset mid-word
    go(32'h0000ABCD);
    chk("rm_b0", if2.bus, 8'hCD);
    @(negedge clk);
    d0 = ndone2;
    #2 rst = 1'b1;
    #1 chk("rm_valid", if2.bus_valid, 0);
    chk("rm_busy", if2.busy, 0);
    chk("rm_busy4", if4.busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rm_no_done", ndone2 - d0, 0);
    go(32'h000000C3);
    chk("rm_c3", if2.bus, 8'hC3);
    @(negedge clk);
    chk("rm_00", {if2.bus_valid, if2.bus}, 9'h100);
    @(negedge clk);
    chk("rm_done", if2.done, 1);
    // start in FIN ignored, then back-to-back in the next cycle
    start = 1'b1;
    yout  = 32'h00004411;
    @(negedge clk);
    chk("fin_start_ign", if2.busy, 0);
    yout = 32'h00003C96;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_b0", if2.bus, 8'h96);
    @(negedge clk);
    chk("b2b_b1", if2.bus, 8'h3C);
    wait_idle();
    // 4-byte word
    go(32'hDEADBEEF);
    chk("n4_b0", if4.bus, 8'hEF);
    @(negedge clk);
    chk("n4_b1", if4.bus, 8'hBE);
    @(negedge clk);
    chk("n4_b2", if4.bus, 8'hAD);
    @(negedge clk);
    chk("n4_b3", if4.bus, 8'hDE);
    @(negedge clk);
    chk("n4_done", if4.done, 1);
    wait_idle();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom % 6) == 0;
      ack   = ($urandom % 3) != 0;
      yout  = $urandom;
      if (($urandom % 300) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    ack   = 1'b1;
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/wrap_out.md
WRAP_OUT -- requirements
Module: wrap_out

Interface
REQ-001 The module SHALL have parameter NBYTES, default 2, giving the number of bytes per result word; legal values are 2 to 8.
REQ-002 The module SHALL have parameter BYTE_W, default 8, giving the bus byte width.
REQ-003 Port clk SHALL be an input of width 1: the system clock; all state changes occur on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: the asynchronous, active-high reset.
REQ-005 Port start SHALL be an input of width 1: a one-cycle request to capture yout and begin transmission.
REQ-006 Port yout SHALL be an input of width NBYTES*BYTE_W: the accelerator result word.
REQ-007 Port bus SHALL be an output of width BYTE_W: the byte currently presented to the consumer.
REQ-008 Port bus_valid SHALL be an output of width 1: bus holds a valid byte.
REQ-009 Port bus_ack SHALL be an input of width 1: the consumer accepts the byte in the same cycle.
REQ-010 Port busy SHALL be an output of width 1: high from capture until done.
REQ-011 Port done SHALL be an output of width 1: a one-cycle pulse after the final byte is accepted.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND and FIN.
REQ-013 In IDLE with start=1, the module SHALL, on that edge, capture yout into a shift register, clear the byte counter to 0 and enter SEND.
REQ-014 In SEND, bus_valid SHALL be 1 and bus SHALL equal the low BYTE_W bits of the shift register; bytes go out least-significant first.
REQ-015 A byte SHALL transfer only on a clock edge where bus_valid=1 and bus_ack=1; bus and bus_valid SHALL be held unchanged while bus_ack=0, with no timeout.
REQ-016 On each transfer that is not the last, the shift register SHALL shift right by BYTE_W and the counter SHALL increment.
REQ-017 On the transfer with counter = NBYTES-1, the FSM SHALL enter FIN and the counter SHALL wrap to 0.
REQ-018 In FIN, done SHALL be 1 for exactly one cycle and bus_valid SHALL be 0; the FSM SHALL then return to IDLE.
REQ-019 busy SHALL be 1 in SEND and FIN and 0 in IDLE.
REQ-020 start asserted while busy=1 SHALL be ignored; it is neither queued nor allowed to corrupt the in-flight word.
REQ-021 start asserted in the same cycle as the FIN-to-IDLE transition SHALL be ignored; start is sampled only in IDLE.
REQ-022 Latency SHALL be as follows: the first byte is valid one cycle after start, and with bus_ack held at 1 done asserts NBYTES+1 cycles after start.
REQ-023 bus SHALL read 0 whenever bus_valid=0.
REQ-024 bus_ack asserted while bus_valid=0 SHALL have no effect.

Reset
REQ-025 On rst=1, the module SHALL asynchronously enter IDLE and clear the shift register and counter to 0.
REQ-026 During reset, the outputs SHALL be bus=0, bus_valid=0, busy=0 and done=0.
REQ-027 Reset asserted mid-transfer SHALL abort the word with no done pulse; the first post-reset start SHALL begin a fresh word at byte 0.

Structure
REQ-028 A shared package wrap_pkg SHALL hold the state encoding (IDLE=2'd0, SEND=2'd1, FIN=2'd2) and the default BYTE_W.
REQ-029 The design SHALL be split into a controller (FSM, busy/done/bus_valid) and one sub-module, wrap_out_dp, containing the shift register, the counter and the bus mux.
REQ-030 wrap_out_dp SHALL expose control inputs ld, shift and rstcnt, and SHALL return a last-byte flag to the controller.

Verification
REQ-031 Basic transfer: NBYTES=2, yout=16'hA55A, start pulse, bus_ack=1 -> bus=5A then A5 on consecutive cycles, done at cycle 3 after start.
REQ-032 Backpressure: yout=16'h1234, bus_ack low for 4 cycles, then high -> bus holds 34 with bus_valid=1 for 4 cycles, then 12, then done.
REQ-033 Start while busy: second start with yout=16'hFFFF during SEND -> output bytes remain the first word's bytes, and exactly one done is produced.
REQ-034 Reset mid-word: rst pulsed after the first byte is accepted -> bus_valid=0 and busy=0 immediately, no done; the next start with 16'h00C3 sends C3 then 00.
REQ-035 Back-to-back: start reasserted in the cycle after done -> the second word transmits correctly, and the counter starts from 0.
REQ-036 NBYTES=4: yout=32'hDEADBEEF, bus_ack=1 -> bus sequence EF, BE, AD, DE, then done at cycle 5.
